// File: rtl/shake_sponge_ctrl_pkg.sv
// Shared types and constants for the SHAKE sponge controller.
package shake_pkg;

    localparam int LANE_W    = 64;
    localparam int STATE_W   = 1600;
    localparam int NUM_LANES = STATE_W / LANE_W;

    // Domain-separation byte for SHAKE and the final pad10*1 bit.
    localparam logic [7:0] DS_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_END  = 8'h80;

    // Rates in 64-bit lanes.
    localparam int SHAKE128_RATE = 21;
    localparam int SHAKE256_RATE = 17;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PAD,
        PERM,
        PERM_WAIT,
        SQUEEZE,
        FIN
    } state_e;

endpackage

// File: rtl/shake_sponge_ctrl_if.sv
// Host-side message and output streams of the sponge controller.
// master = host/consumer side, slave = controller side.
interface shake_sponge_ctrl_if;
    import shake_pkg::*;

    logic [LANE_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic [3:0]        in_last_bytes;
    logic              in_ready;

    logic [LANE_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    modport master (
        output in_data, in_valid, in_last, in_last_bytes, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, in_last_bytes, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

endinterface

// File: rtl/shake_sponge_ctrl_lane_mask.sv
// Combinational lane conditioning: keeps only the valid bytes of a final
// message lane and optionally XORs the SHAKE domain byte at a byte position.
module shake_lane_mask
    import shake_pkg::*;
(
    input  logic [LANE_W-1:0] data_i,
    input  logic              last_i,
    input  logic [3:0]        nbytes_i,
    input  logic              pad_en_i,
    input  logic [2:0]        pad_pos_i,
    output logic [LANE_W-1:0] data_o
);

    // Byte j survives unless this is the last lane and j >= nbytes_i.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        data_o = '0;
        for (int j = 0; j < 8; j++) begin
            if (!last_i || (4'(j) < nbytes_i)) begin
                data_o[8*j +: 8] = data_i[8*j +: 8];
            end
            if (pad_en_i && (pad_pos_i == 3'(j))) begin
                data_o[8*j +: 8] = data_o[8*j +: 8] ^ DS_SHAKE;
            end
        end
    end

endmodule

// File: rtl/shake_sponge_ctrl.sv
// SHAKE128/256 sponge controller: absorbs 64-bit lanes into the Keccak
// state, pads, drives an external permutation via start/done, squeezes.
// Optional build macro SHAKE_PERM_COUNT_EN adds a saturating perm_count output.
module shake_sponge_ctrl
    import shake_pkg::*;
#(
    parameter int RATE_LANES = SHAKE128_RATE,
    parameter int OUTLEN_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OUTLEN_W-1:0] out_lanes,
    shake_sponge_ctrl_if.slave  strm,
    output logic                perm_start,
    output logic [STATE_W-1:0]  perm_state_in,
    input  logic [STATE_W-1:0]  perm_state_out,
    input  logic                perm_done,
    output logic                busy,
    output logic                done
`ifdef SHAKE_PERM_COUNT_EN
    ,
    output logic [15:0]         perm_count
`endif
);

    localparam logic [4:0]          LAST_LANE = 5'(RATE_LANES - 1);
    localparam logic [OUTLEN_W-1:0] ONE       = OUTLEN_W'(1);

    state_e                fsm_q, fsm_d, ret_q, ret_d;
    logic [STATE_W-1:0]    state_q, state_d;
    logic [4:0]            lane_idx_q, lane_idx_d;
    logic [OUTLEN_W-1:0]   remaining_q, remaining_d;
    logic [3:0]            last_bytes_q, last_bytes_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  perm_start_q, perm_start_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef SHAKE_PERM_COUNT_EN
    logic [15:0]           perm_count_q, perm_count_d;
`endif

    logic [LANE_W-1:0]     absorb_lane;
    logic [LANE_W-1:0]     ds_lane;
    logic [LANE_W-1:0]     sel_lane;
    logic                  pad_full;
    logic [4:0]            pad_lane;
    logic [2:0]            pad_byte;

    // A last lane of 8 bytes puts the pad position at byte 0 of the next lane.
    assign pad_full = last_bytes_q[3];
    assign pad_lane = lane_idx_q + {4'b0, pad_full};
    assign pad_byte = pad_full ? 3'd0 : last_bytes_q[2:0];

    shake_lane_mask u_absorb_mask (
        .data_i    (strm.in_data),
        .last_i    (strm.in_last),
        .nbytes_i  (strm.in_last_bytes),
        .pad_en_i  (1'b0),
        .pad_pos_i (3'd0),
        .data_o    (absorb_lane)
    );

    shake_lane_mask u_pad_mask (
        .data_i    ('0),
        .last_i    (1'b1),
        .nbytes_i  (4'd0),
        .pad_en_i  (1'b1),
        .pad_pos_i (pad_byte),
        .data_o    (ds_lane)
    );

    // Output lane mux: state lane selected by lane_idx.
    always_comb begin
        sel_lane = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_idx_q == 5'(i)) sel_lane = state_q[LANE_W*i +: LANE_W];
        end
    end

    // Next-state logic for the sponge FSM, state register and registered outputs.
    always_comb begin
        fsm_d        = fsm_q;
        ret_d        = ret_q;
        state_d      = state_q;
        lane_idx_d   = lane_idx_q;
        remaining_d  = remaining_q;
        last_bytes_d = last_bytes_q;
`ifdef SHAKE_PERM_COUNT_EN
        perm_count_d = perm_count_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d     = '0;
                    remaining_d = out_lanes;
                    lane_idx_d  = '0;
                    fsm_d       = ABSORB;
`ifdef SHAKE_PERM_COUNT_EN
                    perm_count_d = '0;
`endif
                end
            end
            ABSORB: begin
                if (strm.in_valid && in_ready_q) begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (lane_idx_q == 5'(i)) begin
                            state_d[LANE_W*i +: LANE_W] = state_q[LANE_W*i +: LANE_W] ^ absorb_lane;
                        end
                    end
                    last_bytes_d = strm.in_last_bytes;
                    if (strm.in_last) begin
                        fsm_d = PAD;
                    end else if (lane_idx_q == LAST_LANE) begin
                        lane_idx_d = '0;
                        ret_d      = ABSORB;
                        fsm_d      = PERM;
                    end else begin
                        lane_idx_d = lane_idx_q + 5'd1;
                    end
                end
            end
            PAD: begin
                if (pad_full && (lane_idx_q == LAST_LANE)) begin
                    // Message exactly filled the block: permute, then pad at byte 0.
                    last_bytes_d = '0;
                    ret_d        = PAD;
                    fsm_d        = PERM;
                end else begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (pad_lane == 5'(i)) begin
                            state_d[LANE_W*i +: LANE_W] = state_q[LANE_W*i +: LANE_W] ^ ds_lane;
                        end
                    end
                    state_d[LANE_W*RATE_LANES-8 +: 8] = state_d[LANE_W*RATE_LANES-8 +: 8] ^ PAD_END;
                    ret_d = SQUEEZE;
                    fsm_d = PERM;
                end
            end
            PERM: begin
                fsm_d = PERM_WAIT;
            end
            PERM_WAIT: begin
                if (perm_done) begin
                    state_d    = perm_state_out;
                    lane_idx_d = '0;
                    fsm_d      = ret_q;
`ifdef SHAKE_PERM_COUNT_EN
                    if (perm_count_q != 16'hFFFF) perm_count_d = perm_count_q + 16'd1;
`endif
                end
            end
            SQUEEZE: begin
                if (remaining_q == '0) begin
                    fsm_d = FIN;
                end else if (out_valid_q && strm.out_ready) begin
                    remaining_d = remaining_q - ONE;
                    lane_idx_d  = lane_idx_q + 5'd1;
                    if (remaining_q == ONE) begin
                        fsm_d = FIN;
                    end else if (lane_idx_q == LAST_LANE) begin
                        ret_d = SQUEEZE;
                        fsm_d = PERM;
                    end
                end
            end
            FIN: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase

        in_ready_d   = (fsm_d == ABSORB);
        out_valid_d  = (fsm_d == SQUEEZE) && (remaining_d != '0);
        out_last_d   = out_valid_d && (remaining_d == ONE);
        perm_start_d = (fsm_d == PERM);
        busy_d       = (fsm_d != IDLE);
        done_d       = (fsm_d == FIN);
    end

    // Register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q        <= IDLE;
            ret_q        <= IDLE;
            // NOTE: the Keccak state is a plain register, not a RAM, so it is reset like any other flop.
            state_q      <= '0;
            lane_idx_q   <= '0;
            remaining_q  <= '0;
            last_bytes_q <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            perm_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SHAKE_PERM_COUNT_EN
            perm_count_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            fsm_q        <= fsm_d;
            ret_q        <= ret_d;
            state_q      <= state_d;
            lane_idx_q   <= lane_idx_d;
            remaining_q  <= remaining_d;
            last_bytes_q <= last_bytes_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            perm_start_q <= perm_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SHAKE_PERM_COUNT_EN
            perm_count_q <= perm_count_d;
`endif
        end
    end

    assign strm.in_ready  = in_ready_q;
    assign strm.out_valid = out_valid_q;
    assign strm.out_last  = out_last_q;
    assign strm.out_data  = sel_lane;
    assign perm_start     = perm_start_q;
    assign perm_state_in  = state_q;
    assign busy           = busy_q;
    assign done           = done_q;
`ifdef SHAKE_PERM_COUNT_EN
    assign perm_count     = perm_count_q;
`endif

endmodule

// File: tb/tb_shake_sponge_ctrl.sv
// Self-checking bench for shake_sponge_ctrl with an echo permutation
// (24-cycle latency) and a byte-level sponge model.
module tb_shake_sponge_ctrl;

    localparam int R  = 21;
    localparam int RB = R * 8;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } out_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic [15:0]   out_lanes;
    logic          perm_start;
    logic [1599:0] perm_state_in;
    logic [1599:0] perm_state_out;
    logic          perm_done;
    logic          busy;
    logic          done;
`ifdef SHAKE_PERM_COUNT_EN
    logic [15:0]   perm_count;
`endif

    shake_sponge_ctrl_if strm ();

    shake_sponge_ctrl #(.RATE_LANES(R), .OUTLEN_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .out_lanes      (out_lanes),
        .strm           (strm),
        .perm_start     (perm_start),
        .perm_state_in  (perm_state_in),
        .perm_state_out (perm_state_out),
        .perm_done      (perm_done),
        .busy           (busy),
        .done           (done)
`ifdef SHAKE_PERM_COUNT_EN
        ,
        .perm_count     (perm_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    out_t          exp_q[$];
    logic [63:0]   out_hist[$];
    int            exp_perms;
    logic [1599:0] exp_state;
    int            perm_cnt;
    int            done_cnt;
    int            stall_cnt;
    logic [1599:0] last_perm_in;
    int            ready_mode;
    int            rcnt;
    logic          stall_pending;
    logic [63:0]   stall_data;
    logic          stall_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lane_of(input logic [1599:0] v, input int i);
        return v[64*i +: 64];
    endfunction

    function automatic logic [63:0] hist(input int k);
        if (out_hist.size() > k) return out_hist[k];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    // Byte-level sponge with identity permutation: expected lanes, perm count, final state.
    task automatic model(input byte unsigned msg[$], input int n_out);
        byte unsigned s[200];
        int           pos;
        logic [63:0]  ln;
        out_t         e;
        foreach (s[i]) s[i] = 8'h00;
        exp_perms = 0;
        pos = 0;
        exp_q.delete();
        foreach (msg[i]) begin
            s[pos] = s[pos] ^ msg[i];
            pos++;
            if (pos == RB) begin
                exp_perms++;
                pos = 0;
            end
        end
        s[pos]    = s[pos] ^ 8'h1F;
        s[RB-1]   = s[RB-1] ^ 8'h80;
        exp_perms++;
        for (int i = 0; i < 200; i++) exp_state[8*i +: 8] = s[i];
        for (int k = 0; k < n_out; k++) begin
            if (k > 0 && (k % R) == 0) exp_perms++;
            for (int b = 0; b < 8; b++) ln[8*b +: 8] = s[(k % R)*8 + b];
            e.data = ln;
            e.last = (k == n_out - 1);
            exp_q.push_back(e);
        end
    endtask

    // Echo permutation: returns the state it was given 24 cycles later.
    initial begin
        logic [1599:0] cap;
        perm_done      = 1'b0;
        perm_state_out = '0;
        forever begin
            @(negedge clk);
            if (perm_start && !reset) begin
                cap = perm_state_in;
                repeat (23) @(posedge clk);
                #1;
                perm_state_out = cap;
                perm_done      = 1'b1;
                @(posedge clk);
                #1;
                perm_done      = 1'b0;
            end
        end
    end

    // Output consumer: always ready, or ready one cycle in three.
    initial begin
        strm.out_ready = 1'b1;
        rcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            strm.out_ready = (ready_mode == 0) ? 1'b1 : ((rcnt % 3) == 0);
        end
    end

    // Compare process: output lanes against the model, stall stability, event counts.
    initial begin
        out_t e;
        stall_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_pending = 1'b0;
            end else begin
                if (perm_start) begin
                    perm_cnt++;
                    last_perm_in = perm_state_in;
                end
                if (done) done_cnt++;
                if (stall_pending && !strm.out_valid) check("stall_valid", 64'd0, 64'd1);
                if (strm.out_valid) begin
                    if (stall_pending) begin
                        check("stall_data", strm.out_data, stall_data);
                        check("stall_last", {63'b0, strm.out_last}, {63'b0, stall_last});
                    end
                    if (strm.out_ready) begin
                        out_hist.push_back(strm.out_data);
                        if (exp_q.size() == 0) begin
                            check("extra_lane", 64'd1, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("out_data", strm.out_data, e.data);
                            check("out_last", {63'b0, strm.out_last}, {63'b0, e.last});
                        end
                        stall_pending = 1'b0;
                    end else begin
                        if (!stall_pending) stall_cnt++;
                        stall_pending = 1'b1;
                        stall_data    = strm.out_data;
                        stall_last    = strm.out_last;
                    end
                end else begin
                    stall_pending = 1'b0;
                end
            end
        end
    end

    task automatic send_lane(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int n = 0;
        strm.in_data       = d;
        strm.in_last       = last;
        strm.in_last_bytes = nb;
        strm.in_valid      = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!strm.in_ready && n < 200);
        if (!strm.in_ready) check("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        strm.in_valid = 1'b0;
        strm.in_last  = 1'b0;
    endtask

    // Splits a byte message into lanes; unused bytes of the last lane carry 0xEE.
    task automatic send_msg(input byte unsigned msg[$]);
        int          len = msg.size();
        int          nl;
        int          nb;
        logic [63:0] d;
        nl = (len == 0) ? 1 : (len + 7) / 8;
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < 8; b++) begin
                d[8*b +: 8] = (l*8 + b < len) ? msg[l*8 + b] : 8'hEE;
            end
            nb = (l == nl - 1) ? len - 8*l : 8;
            send_lane(d, l == nl - 1, 4'(nb));
        end
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        @(negedge clk);
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {63'b0, done}, 64'd1);
    endtask

    task automatic run_hash(input byte unsigned msg[$], input int n_out, input bit ghost);
        model(msg, n_out);
        perm_cnt  = 0;
        done_cnt  = 0;
        stall_cnt = 0;
        out_hist.delete();
        out_lanes = 16'(n_out);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("in_ready_after_start", {63'b0, strm.in_ready}, 64'd1);
        if (ghost) begin
            out_lanes = 16'(n_out + 4);
            start     = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        send_msg(msg);
        wait_done(4000);
        @(negedge clk);
        check("busy_after_done", {63'b0, busy}, 64'd0);
        check("done_one_cycle", {63'b0, done}, 64'd0);
        check("lanes_missing", 64'(exp_q.size()), 64'd0);
        check("perm_starts", 64'(perm_cnt), 64'(exp_perms));
        check("done_count", 64'(done_cnt), 64'd1);
        for (int i = 0; i < 25; i++) begin
            check($sformatf("perm_in_lane%0d", i), lane_of(last_perm_in, i), lane_of(exp_state, i));
        end
`ifdef SHAKE_PERM_COUNT_EN
        check("perm_count", 64'(perm_count), 64'(exp_perms));
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        byte unsigned m[$];
        int           n;
        reset              = 1'b1;
        start              = 1'b0;
        out_lanes          = '0;
        strm.in_data       = '0;
        strm.in_valid      = 1'b0;
        strm.in_last       = 1'b0;
        strm.in_last_bytes = '0;
        ready_mode         = 0;
        perm_cnt           = 0;
        done_cnt           = 0;
        stall_cnt          = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   {63'b0, strm.in_ready},  64'd0);
        check("rst_out_valid",  {63'b0, strm.out_valid}, 64'd0);
        check("rst_out_last",   {63'b0, strm.out_last},  64'd0);
        check("rst_perm_start", {63'b0, perm_start},     64'd0);
        check("rst_busy",       {63'b0, busy},           64'd0);
        check("rst_done",       {63'b0, done},           64'd0);
        check("rst_out_data",   strm.out_data,           64'd0);
        check("rst_state_zero", {63'b0, |perm_state_in}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Empty message, two output lanes.
        m.delete();
        run_hash(m, 2, 1'b0);
        check("t1_nout", 64'(out_hist.size()), 64'd2);
        check("t1_lane0", hist(0), 64'h1F);
        check("t1_lane1", hist(1), 64'h0);
        check("t1_perms", 64'(perm_cnt), 64'd1);

        // Three-byte message.
        m.delete();
        m.push_back(8'h0A); m.push_back(8'h0B); m.push_back(8'h0C);
        run_hash(m, 1, 1'b0);
        check("t2_lane0", hist(0), 64'h1F0C0B0A);
        check("t2_lane20", lane_of(last_perm_in, 20), 64'h8000_0000_0000_0000);

        // Exactly one full block: padding needs its own block.
        m.delete();
        for (int k = 0; k < RB; k++) m.push_back(8'(k / 8));
        run_hash(m, 1, 1'b0);
        check("t3_perms", 64'(perm_cnt), 64'd2);
        check("t3_lane0", hist(0), 64'h1F);

        // Squeeze across a block boundary.
        m.delete();
        run_hash(m, 22, 1'b0);
        check("t4_nout", 64'(out_hist.size()), 64'd22);
        check("t4_lane20", hist(20), 64'h8000_0000_0000_0000);
        check("t4_lane21", hist(21), 64'h1F);
        check("t4_perms", 64'(perm_cnt), 64'd2);

        // Multi-block absorb, throttled consumer, start pulsed while busy.
        m.delete();
        for (int k = 0; k < RB + 3; k++) m.push_back(8'(k * 7 + 1));
        ready_mode = 1;
        run_hash(m, 5, 1'b1);
        ready_mode = 0;
        check("t5_nout", 64'(out_hist.size()), 64'd5);
        check("t5_stalls_seen", {63'b0, stall_cnt > 0}, 64'd1);

        // Reset during PERM_WAIT; late perm_done must be ignored.
        perm_cnt = 0;
        done_cnt = 0;
        m.delete();
        out_lanes = 16'd2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_msg(m);
        n = 0;
        while (perm_cnt == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_perm_started", 64'(perm_cnt), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_busy",       {63'b0, busy},           64'd0);
        check("t6_in_ready",   {63'b0, strm.in_ready},  64'd0);
        check("t6_out_valid",  {63'b0, strm.out_valid}, 64'd0);
        check("t6_perm_start", 64'(perm_cnt),           64'd1);
        check("t6_state_zero", {63'b0, |perm_state_in}, 64'd0);
        check("t6_no_done",    64'(done_cnt),           64'd0);
        @(posedge clk);
        #1;

        // Zero output lanes: straight from squeeze to done.
        m.delete();
        run_hash(m, 0, 1'b0);
        check("t7_nout", 64'(out_hist.size()), 64'd0);
        check("t7_perms", 64'(perm_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
